// File: rtl/cv32e40p_alu_ft_reconfig_ctrl.sv
// Reconfiguration controller for the quad-ALU TMR EX stage: error counting, permanent-fault
// declaration and spare (ALU3) switch-in. Optional macro ALU_FT_ERR_DECAY_EN enables periodic count decay.
module cv32e40p_alu_ft_reconfig_ctrl #(
    parameter int ERR_CNT_W    = 4,
    parameter int PERM_THRESH  = 8,
    parameter int WAKE_CYCLES  = 2,
    parameter int DECAY_PERIOD = 1024
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid_i,
    input  logic [3:0]             err_detected_alu_i,
    input  logic                   ex_ready_i,
    output logic [2:0]             sel_mux_ex_o,
    output logic [3:0]             clock_en_o,
    output logic [3:0]             permanent_faulty_alu_o,
    output logic [4*ERR_CNT_W-1:0] err_count_o,
    output logic [3:0]             perf_counter_permanent_faulty_alu_o,
    output logic                   reconfig_busy_o,
    output logic                   fatal_o,
    output logic [2:0]             dbg_state_o
);

    typedef enum logic [2:0] {
        ST_NORMAL   = 3'd0,
        ST_WAKE     = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_SWITCH   = 3'd3,
        ST_DEGRADED = 3'd4,
        ST_FAIL     = 3'd5
    } state_t;

    localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [ERR_CNT_W-1:0] THRESH  = ERR_CNT_W'(PERM_THRESH);
    localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    state_t               r_state, w_state_nxt;
    logic [2:0]           r_sel, w_sel_nxt;
    logic [3:0]           r_clk_en, w_clk_en_nxt;
    logic [3:0]           r_perm, r_perf;
    logic [ERR_CNT_W-1:0] r_cnt [4];
    logic [ERR_CNT_W-1:0] w_cnt_nxt [4];
    logic                 r_spare_used, w_spare_used_nxt;
    logic [1:0]           r_target, w_target_nxt;
    logic [WAKE_W-1:0]    r_wake_cnt, w_wake_cnt_nxt;
    logic [3:0]           w_inc, w_new_perm;
    logic                 w_decay_tick;
    logic [2:0]           w_f_act;
    logic                 w_spare_avail, w_spare_fault;
    logic [2:0]           w_nfault, w_neff;
    logic [1:0]           w_low_idx;

`ifdef ALU_FT_ERR_DECAY_EN
    localparam int DEC_W = $clog2(DECAY_PERIOD);
    logic [DEC_W-1:0] r_decay_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || r_decay_cnt == DEC_W'(DECAY_PERIOD - 1)) r_decay_cnt <= '0;
        else                                                  r_decay_cnt <= r_decay_cnt + 1'b1;
    end
    assign w_decay_tick = (r_decay_cnt == DEC_W'(DECAY_PERIOD - 1));
`else
    assign w_decay_tick = 1'b0;
`endif

    // ALU3 only counts while its clock runs (waking or swapped in); faulty ALUs are frozen.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            w_inc[k] = alu_valid_i && err_detected_alu_i[k] && !r_perm[k] && (k < 3 || r_clk_en[3]);
            w_cnt_nxt[k] = r_cnt[k];
            if (w_inc[k]) begin
                if (r_cnt[k] != CNT_MAX) w_cnt_nxt[k] = r_cnt[k] + 1'b1;
            end else if (w_decay_tick && !r_perm[k] && r_cnt[k] != '0) begin
                w_cnt_nxt[k] = r_cnt[k] - 1'b1;
            end
            w_new_perm[k] = !r_perm[k] && (w_cnt_nxt[k] >= THRESH);
        end
    end

    // Faulty ALUs still feeding the voter; an available spare absorbs one of them.
    assign w_f_act       = r_perm[2:0] & r_sel;
    assign w_spare_fault = r_spare_used & r_perm[3];
    assign w_spare_avail = !r_spare_used && !r_perm[3];
    assign w_nfault      = 3'(w_f_act[0]) + 3'(w_f_act[1]) + 3'(w_f_act[2]) + 3'(w_spare_fault);
    assign w_neff        = w_nfault - 3'(w_spare_avail && (|w_f_act));
    assign w_low_idx     = w_f_act[0] ? 2'd0 : (w_f_act[1] ? 2'd1 : 2'd2);

    always_comb begin
        w_state_nxt      = r_state;
        w_sel_nxt        = r_sel;
        w_clk_en_nxt     = r_clk_en;
        w_spare_used_nxt = r_spare_used;
        w_target_nxt     = r_target;
        w_wake_cnt_nxt   = r_wake_cnt;
        case (r_state)
            ST_NORMAL: begin
                if (w_neff >= 3'd2) begin
                    w_state_nxt = ST_FAIL;
                end else if (r_spare_used && w_nfault != 3'd0) begin
                    w_state_nxt = ST_DEGRADED;
                end else if (w_spare_avail && (|w_f_act)) begin
                    w_state_nxt     = ST_WAKE;
                    w_target_nxt    = w_low_idx;
                    w_clk_en_nxt[3] = 1'b1;
                    w_wake_cnt_nxt  = '0;
                end
            end
            ST_WAKE, ST_DRAIN: begin
                if (r_perm[3]) begin
                    w_state_nxt     = ST_NORMAL;
                    w_clk_en_nxt[3] = 1'b0;
                end else if (r_state == ST_WAKE) begin
                    if (r_wake_cnt == WAKE_LAST) w_state_nxt = ST_DRAIN;
                    else                         w_wake_cnt_nxt = r_wake_cnt + 1'b1;
                end else if (ex_ready_i) begin
                    w_state_nxt = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                w_sel_nxt[r_target]    = 1'b0;
                w_clk_en_nxt[r_target] = 1'b0;
                w_spare_used_nxt       = 1'b1;
                w_state_nxt            = ST_NORMAL;
            end
            ST_DEGRADED: begin
                if (w_nfault >= 3'd2) w_state_nxt = ST_FAIL;
            end
            ST_FAIL: w_state_nxt = ST_FAIL;
            default: w_state_nxt = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_NORMAL;
            r_sel        <= 3'b111;
            r_clk_en     <= 4'b0111;
            r_perm       <= '0;
            r_perf       <= '0;
            r_spare_used <= 1'b0;
            r_target     <= '0;
            r_wake_cnt   <= '0;
            for (int k = 0; k < 4; k++) r_cnt[k] <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_sel        <= w_sel_nxt;
            r_clk_en     <= w_clk_en_nxt;
            r_perm       <= r_perm | w_new_perm;
            r_perf       <= w_new_perm;
            r_spare_used <= w_spare_used_nxt;
            r_target     <= w_target_nxt;
            r_wake_cnt   <= w_wake_cnt_nxt;
            for (int k = 0; k < 4; k++) r_cnt[k] <= w_cnt_nxt[k];
        end
    end

    assign sel_mux_ex_o                        = r_sel;
    assign clock_en_o                          = r_clk_en;
    assign permanent_faulty_alu_o              = r_perm;
    assign perf_counter_permanent_faulty_alu_o = r_perf;
    assign err_count_o                         = {r_cnt[3], r_cnt[2], r_cnt[1], r_cnt[0]};
    assign reconfig_busy_o                     = (r_state == ST_WAKE) || (r_state == ST_DRAIN) ||
                                                 (r_state == ST_SWITCH);
    assign fatal_o                             = (r_state == ST_FAIL);
    assign dbg_state_o                         = r_state;

endmodule
